hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_params_pkg.sv | 7 +
 rtl/cpu_structs_pkg.sv | 8 +
 rtl/sb_fifo.sv | 76 +++++++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg: CPU-wide sizing constants shared by the pipeline control blocks.
//   INFLIGHT_DEPTH_DEF : default number of issued-but-unretired instructions
//   REG_IDX_W          : architectural register index width
package cpu_params_pkg;
  localparam int INFLIGHT_DEPTH_DEF = 4;
  localparam int REG_IDX_W          = 5;
endpackage

// File: rtl/cpu_structs_pkg.sv
// cpu_structs_pkg: shared pipeline structures.
//   SB_ENTRY : scoreboard entry, destination register and write flag
package cpu_structs_pkg;
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
  } SB_ENTRY;
endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: in-order scoreboard FIFO holding one SB_ENTRY per in-flight instruction.
// Ports:
//   clk_in, reset_in  : clock, synchronous active-high reset
//   push_i            : append push_entry_i at tail (ignored while flush_i)
//   pop_i             : drop head entry (caller guarantees non-empty)
//   flush_i, keep_i   : truncate to min(keep_i, count after pop), oldest kept
//   entries_o         : raw storage, indexed by slot
//   valid_o           : per-slot valid, derived from head and count
//   head_o, count_o   : head slot index and number of valid entries
module sb_fifo
  import cpu_structs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [2:0]               keep_i,
  input  SB_ENTRY                  push_entry_i,
  output SB_ENTRY [DEPTH-1:0]      entries_o,
  output logic [DEPTH-1:0]         valid_o,
  output logic [$clog2(DEPTH)-1:0] head_o,
  output logic [2:0]               count_o
);
  localparam int PW = $clog2(DEPTH);

  SB_ENTRY [DEPTH-1:0] mem_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0]    cnt_q, cnt_d, cnt_after_pop, keep_clamped;

  assign cnt_after_pop = cnt_q - {2'b00, pop_i};
  assign keep_clamped  = (keep_i > 3'(DEPTH)) ? 3'(DEPTH) : keep_i;

  always_comb begin
    head_d = head_q + PW'(pop_i);
    tail_d = tail_q;
    cnt_d  = cnt_after_pop;
    if (flush_i) begin
      cnt_d  = (keep_clamped < cnt_after_pop) ? keep_clamped : cnt_after_pop;
      // Tail is rebuilt from the new head; cnt_d == DEPTH wraps back onto head.
      tail_d = head_d + PW'(cnt_d);
    end else if (push_i) begin
      cnt_d  = cnt_after_pop + 3'd1;
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: validity comes only from head/count.
  always_ff @(posedge clk_in) begin
    if (!reset_in && push_i && !flush_i) mem_q[tail_q] <= push_entry_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW-1:0] off;
    assign off        = PW'(i) - head_q;
    assign valid_o[i] = (3'(off) < cnt_q);
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign count_o   = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: issue/retire scoreboard with RAW hazard detection.
// Ports:
//   clk_in, reset_in          : clock, synchronous active-high reset
//   cpu_halt                  : block all new issue
//   pipe_flush, flush_keep    : drop younger entries, keep flush_keep oldest
//   iss_valid, iss_rs1/2/rd   : decode-stage instruction and its registers
//   iss_rs1_rd/rs2_rd/rd_wr   : source used / destination written flags
//   iss_rdy                   : instruction may issue this cycle
//   ret_valid                 : oldest in-flight instruction retires
//   occupancy                 : registered number of in-flight entries
//   hazard_stall              : issue blocked only by a RAW hazard
//   stall_cnt                 : saturating count of hazard_stall cycles
//   ret_err                   : sticky, retire seen while empty
module hazard_ctrl
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int INFLIGHT_DEPTH = INFLIGHT_DEPTH_DEF
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        cpu_halt,
  input  logic        pipe_flush,
  input  logic [2:0]  flush_keep,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_rs1_rd,
  input  logic        iss_rs2_rd,
  input  logic        iss_rd_wr,
  output logic        iss_rdy,
  input  logic        ret_valid,
  output logic [2:0]  occupancy,
  output logic        hazard_stall,
  output logic [31:0] stall_cnt,
  output logic        ret_err
);
  localparam int PW = $clog2(INFLIGHT_DEPTH);

  SB_ENTRY [INFLIGHT_DEPTH-1:0] entries;
  logic [INFLIGHT_DEPTH-1:0]    valid, hit;
  logic [PW-1:0]                head;
  logic [2:0]                   count;
  logic                         hazard, pop, iss_fire;
  logic [31:0]                  stall_cnt_q, stall_cnt_d;
  logic                         ret_err_q, ret_err_d;
  SB_ENTRY                      push_entry;

  assign push_entry = '{rd: iss_rd, wr: iss_rd_wr};
  assign pop        = ret_valid && (count != 3'd0);

  sb_fifo #(.DEPTH(INFLIGHT_DEPTH)) u_sb_fifo (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .push_i       (iss_fire),
    .pop_i        (pop),
    .flush_i      (pipe_flush),
    .keep_i       (flush_keep),
    .push_entry_i (push_entry),
    .entries_o    (entries),
    .valid_o      (valid),
    .head_o       (head),
    .count_o      (count)
  );

  for (genvar i = 0; i < INFLIGHT_DEPTH; i++) begin : g_cmp
    SB_ENTRY e;
    logic    bypass, m1, m2;
    assign e      = entries[i];
    // The retiring head writes back this cycle, so it no longer blocks.
    assign bypass = ret_valid && (head == PW'(i));
    assign m1     = iss_rs1_rd && (iss_rs1 != 5'd0) && (iss_rs1 == e.rd);
    assign m2     = iss_rs2_rd && (iss_rs2 != 5'd0) && (iss_rs2 == e.rd);
    assign hit[i] = valid[i] && e.wr && (e.rd != 5'd0) && !bypass && (m1 || m2);
  end
  assign hazard = |hit;

  assign iss_rdy = !reset_in && !cpu_halt && !pipe_flush && !hazard &&
                   ((count < 3'(INFLIGHT_DEPTH)) || ret_valid);
  assign iss_fire     = iss_valid && iss_rdy;
  assign hazard_stall = iss_valid && hazard && !cpu_halt && !pipe_flush && !reset_in;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    ret_err_d = ret_err_q || (ret_valid && (count == 3'd0));
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stall_cnt_q <= '0;
      ret_err_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      ret_err_q   <= ret_err_d;
    end
  end

  assign occupancy = count;
  assign stall_cnt = stall_cnt_q;
  assign ret_err   = ret_err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int D = 4;

  logic        clk_in = 1'b0;
  logic        reset_in, cpu_halt, pipe_flush, iss_valid;
  logic [2:0]  flush_keep;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_rd, iss_rs2_rd, iss_rd_wr, ret_valid;
  logic        iss_rdy, hazard_stall, ret_err;
  logic [2:0]  occupancy;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.INFLIGHT_DEPTH(D)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt),
    .pipe_flush(pipe_flush), .flush_keep(flush_keep), .iss_valid(iss_valid),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rs1_rd(iss_rs1_rd), .iss_rs2_rd(iss_rs2_rd), .iss_rd_wr(iss_rd_wr),
    .iss_rdy(iss_rdy), .ret_valid(ret_valid), .occupancy(occupancy),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt), .ret_err(ret_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [4:0] rd; bit wr; } ent_t;
  typedef struct { bit rdy; bit hs; logic [2:0] occ; logic [31:0] sc; bit err; } exp_t;

  ent_t        mq[$];     // in-flight instructions, oldest first
  exp_t        sb[$];     // expected outputs, one per cycle
  logic [31:0] m_sc;
  bit          m_err;
  int          checks = 0, errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, req, $time);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("iss_rdy", 32'(iss_rdy), 32'(e.rdy));
      chk("hazard_stall", 32'(hazard_stall), 32'(e.hs));
      chk("occupancy", 32'(occupancy), 32'(e.occ));
      chk("stall_cnt", stall_cnt, e.sc);
      chk("ret_err", 32'(ret_err), 32'(e.err));
    end
  end

  // One cycle: drive inputs, predict outputs from the model, advance model at the edge.
  task automatic step(input bit rst, input bit halt, input bit fl, input bit [2:0] keep,
                      input bit iv, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit [4:0] rd, input bit u1, input bit u2, input bit w,
                      input bit rv);
    bit haz, rdy, hs;
    int n, k;
    exp_t e;
    ent_t ne;
    reset_in = rst; cpu_halt = halt; pipe_flush = fl; flush_keep = keep;
    iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
    iss_rs1_rd = u1; iss_rs2_rd = u2; iss_rd_wr = w; ret_valid = rv;
    n = mq.size();
    haz = 0;
    for (int i = 0; i < n; i++) begin
      if (!(i == 0 && rv) && mq[i].wr && mq[i].rd != 0 &&
          ((u1 && rs1 != 0 && rs1 == mq[i].rd) || (u2 && rs2 != 0 && rs2 == mq[i].rd)))
        haz = 1;
    end
    rdy = !rst && !halt && !fl && !haz && (n < D || rv);
    hs  = iv && haz && !halt && !fl && !rst;
    e.rdy = rdy; e.hs = hs; e.occ = 3'(n); e.sc = m_sc; e.err = m_err;
    sb.push_back(e);
    @(posedge clk_in);
    if (rst) begin
      mq.delete(); m_sc = 0; m_err = 0;
    end else begin
      if (hs && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (rv) begin
        if (n > 0) void'(mq.pop_front());
        else m_err = 1;
      end
      if (fl) begin
        k = (keep > D) ? D : int'(keep);
        while (mq.size() > k) void'(mq.pop_back());
      end else if (iv && rdy) begin
        ne.rd = rd; ne.wr = w;
        mq.push_back(ne);
      end
    end
    #1;
  endtask

  task automatic idle(input bit rv);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rv);
  endtask
  task automatic wr(input bit [4:0] rd, input bit rv);
    step(0, 0, 0, 0, 1, 0, 0, rd, 0, 0, 1, rv);
  endtask
  task automatic rdr(input bit [4:0] rs, input bit rv);
    step(0, 0, 0, 0, 1, rs, 0, 9, 1, 0, 1, rv);
  endtask
  task automatic flush(input bit [2:0] keep, input bit rv);
    step(0, 0, 1, keep, 0, 0, 0, 0, 0, 0, 0, rv);
  endtask

  initial begin
    m_sc = 0; m_err = 0;
    reset_in = 1; cpu_halt = 0; pipe_flush = 0; flush_keep = 0; iss_valid = 0;
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rs1_rd = 0; iss_rs2_rd = 0;
    iss_rd_wr = 0; ret_valid = 0;
    @(posedge clk_in); #1;
    step(1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW on x5, released in the retire cycle
    wr(5, 0);
    repeat (3) rdr(5, 0);
    rdr(5, 1);
    idle(1);

    // Fill to depth, blocked issue, then retire+issue while full
    for (int i = 0; i < 4; i++) wr(5'(10 + i), 0);
    wr(14, 0);
    wr(14, 1);
    repeat (4) idle(1);

    // Flush with same-cycle retire keeps the second-oldest
    wr(1, 0); wr(2, 0); wr(3, 0);
    flush(1, 1);
    rdr(2, 0);
    rdr(3, 0);
    flush(7, 0);      // clamps to depth, nothing dropped
    flush(0, 0);

    // rd=0 never blocks
    wr(0, 0);
    rdr(0, 0);
    flush(0, 0);

    // Retire while empty is sticky until reset
    idle(1);
    idle(0); idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    // Saturation of stall_cnt, then reset mid-stall
    wr(7, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    m_sc = 32'hFFFF_FFFD;
    idle(0);
    release dut.stall_cnt_q;
    repeat (4) rdr(7, 0);
    step(1, 0, 0, 0, 1, 7, 0, 9, 1, 0, 1, 0);
    idle(0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(99) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0,
           3'($urandom_range(7)), $urandom_range(3) != 0,
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(2) == 0);
    end

    @(negedge clk_in); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
